// File: rtl/ext_int_arb_pkg.sv
// Shared definitions for the external interrupt arbiter.
// Holds the register offsets and the source-ID type. It also holds the bus
// response state type and small helpers that turn byte offsets into word
// indices for address decode.
package int_arb_pkg;

  // Source IDs run 1..31; ID 0 means "no source".
  localparam int ID_W = 5;
  typedef logic [ID_W-1:0] arb_id_t;

  // Byte offsets of the register map.
  localparam logic [7:0] ARB_PENDING   = 8'h00;
  localparam logic [7:0] ARB_ENABLE    = 8'h04;
  localparam logic [7:0] ARB_MODE      = 8'h08;
  localparam logic [7:0] ARB_THRESH    = 8'h0C;
  localparam logic [7:0] ARB_CLAIM     = 8'h10;
  localparam logic [7:0] ARB_PRIO_BASE = 8'h20;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_RESP = 1'b1
  } bus_state_e;

  // Word index of a byte address; the low two address bits are ignored.
  function automatic logic [5:0] word_of(input logic [7:0] addr);
    return addr[7:2];
  endfunction

  // Word index of the PRIORITY register of source i.
  function automatic logic [5:0] prio_word(input int i);
    return word_of(ARB_PRIO_BASE) + 6'(i);
  endfunction

endpackage

// File: rtl/ext_int_arb_if.sv
// Register access port of the interrupt arbiter.
//  bus_sel   : access strobe, one cycle per access (master -> slave)
//  bus_we    : 1 = write, 0 = read                 (master -> slave)
//  bus_addr  : byte address, bits [1:0] ignored    (master -> slave)
//  bus_wdata : write data                          (master -> slave)
//  bus_rdata : registered read data                (slave -> master)
//  bus_ready : one-cycle completion pulse          (slave -> master)
interface ext_int_arb_if;
  logic        bus_sel;
  logic        bus_we;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;

  modport master (
    output bus_sel, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_ready
  );

  modport slave (
    input  bus_sel, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_ready
  );
endinterface

// File: rtl/ext_int_arb_prio_sel.sv
// Combinational winner selection for the interrupt arbiter.
//  eligible     : per-source eligibility, bit i = source i
//  prio         : per-source priority
//  win_id       : highest-priority eligible source, lowest ID on ties, 0 if none
//  any_eligible : at least one source is eligible
module irq_prio_sel
  import int_arb_pkg::*;
#(
  parameter int SOURCES = 8,
  parameter int PRIO_W  = 3
) (
  input  logic [SOURCES:1]             eligible,
  input  logic [SOURCES:1][PRIO_W-1:0] prio,
  output arb_id_t                      win_id,
  output logic                         any_eligible
);

  logic [PRIO_W-1:0] best;

  // Ascending scan with a strict compare, so an equal priority found later
  // (higher ID) never displaces the current holder.
  always_comb begin
    win_id       = '0;
    best         = '0;
    any_eligible = 1'b0;
    for (int i = 1; i <= SOURCES; i++) begin
      if (eligible[i] && (!any_eligible || (prio[i] > best))) begin
        any_eligible = 1'b1;
        best         = prio[i];
        win_id       = arb_id_t'(i);
      end
    end
  end

endmodule

// File: rtl/ext_int_arb.sv
// External interrupt arbiter: merges SOURCES peripheral lines into the core's
// single exti input. It provides a per-source edge/level gateway, enable and
// priority, a global threshold, and a claim/complete handshake over a small
// register port.
//  clk     : core clock
//  rst_n   : asynchronous active-low reset
//  irq_src : raw peripheral requests (asynchronous), bit i = source i
//  bus     : register access port (slave side)
//  exti    : registered level interrupt to the core
module ext_int_arb
  import int_arb_pkg::*;
#(
  parameter int SOURCES = 8,
  parameter int PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SOURCES:1]   irq_src,
  ext_int_arb_if.slave       bus,
  output logic               exti
);

  logic [SOURCES:1]             sync1_q, sync1_d;
  logic [SOURCES:1]             sync2_q, sync2_d;
  logic [SOURCES:1]             edge_pend_q, edge_pend_d;
  logic [SOURCES:1]             in_svc_q, in_svc_d;
  logic [SOURCES:1]             enable_q, enable_d;
  logic [SOURCES:1]             mode_q, mode_d;
  logic [PRIO_W-1:0]            thr_q, thr_d;
  logic [SOURCES:1][PRIO_W-1:0] prio_q, prio_d;
  logic [31:0]                  rdata_q, rdata_d;
  logic                         exti_q, exti_d;
  bus_state_e                   state_q, state_d;

  logic [SOURCES:1] rise;
  logic [SOURCES:1] pending;
  logic [SOURCES:1] eligible;
  logic [SOURCES:1] claim_hit;
  logic [5:0]       word;
  arb_id_t          cmpl_id;
  arb_id_t          win_id;
  logic             any_eligible;
  logic [31:0]      rd_val;
  logic             unused_bus;

  assign word       = word_of(bus.bus_addr);
  assign cmpl_id    = bus.bus_wdata[ID_W-1:0];
  assign unused_bus = ^{bus.bus_addr[1:0], bus.bus_wdata};

  // The edge is taken while s (sync2) is being loaded. The latch is then set
  // at the same edge that s rises, which keeps irq-to-exti at three cycles.
  assign rise = sync1_q & ~sync2_q;

  // Edge sources use the latch; level sources follow s, masked while in service.
  assign pending = (edge_pend_q & mode_q) | (sync2_q & ~in_svc_q & ~mode_q);

  always_comb begin
    eligible = '0;
    for (int i = 1; i <= SOURCES; i++) begin
      eligible[i] = pending[i] && enable_q[i] && !in_svc_q[i] && (prio_q[i] > thr_q);
    end
  end

  irq_prio_sel #(
    .SOURCES (SOURCES),
    .PRIO_W  (PRIO_W)
  ) u_prio_sel (
    .eligible     (eligible),
    .prio         (prio_q),
    .win_id       (win_id),
    .any_eligible (any_eligible)
  );

  // Read mux; unmapped words return 0.
  always_comb begin
    rd_val = '0;
    case (word)
      word_of(ARB_PENDING): rd_val = 32'({pending, 1'b0});
      word_of(ARB_ENABLE):  rd_val = 32'({enable_q, 1'b0});
      word_of(ARB_MODE):    rd_val = 32'({mode_q, 1'b0});
      word_of(ARB_THRESH):  rd_val = 32'(thr_q);
      word_of(ARB_CLAIM):   rd_val = 32'(win_id);
      default: begin
        for (int i = 1; i <= SOURCES; i++) begin
          if (word == prio_word(i)) rd_val = 32'(prio_q[i]);
        end
      end
    endcase
  end

  always_comb begin
    sync1_d   = irq_src;
    sync2_d   = sync1_q;
    enable_d  = enable_q;
    mode_d    = mode_q;
    thr_d     = thr_q;
    prio_d    = prio_q;
    in_svc_d  = in_svc_q;
    rdata_d   = '0;
    exti_d    = any_eligible;
    claim_hit = '0;
    state_d   = bus.bus_sel ? BUS_RESP : BUS_IDLE;

    if (bus.bus_sel) begin
      if (bus.bus_we) begin
        case (word)
          word_of(ARB_ENABLE): enable_d = bus.bus_wdata[SOURCES:1];
          word_of(ARB_MODE):   mode_d   = bus.bus_wdata[SOURCES:1];
          word_of(ARB_THRESH): thr_d    = bus.bus_wdata[PRIO_W-1:0];
          word_of(ARB_CLAIM): begin
            // Complete: IDs 0 and out-of-range never match; clearing a source
            // that is not in service leaves it unchanged.
            for (int i = 1; i <= SOURCES; i++) begin
              if (cmpl_id == arb_id_t'(i)) in_svc_d[i] = 1'b0;
            end
          end
          default: begin
            for (int i = 1; i <= SOURCES; i++) begin
              if (word == prio_word(i)) prio_d[i] = bus.bus_wdata[PRIO_W-1:0];
            end
          end
        endcase
      end else begin
        rdata_d = rd_val;
        if (word == word_of(ARB_CLAIM)) begin
          for (int i = 1; i <= SOURCES; i++) begin
            if (win_id == arb_id_t'(i)) claim_hit[i] = 1'b1;
          end
        end
      end
    end

    in_svc_d    = in_svc_d | claim_hit;
    // A fresh edge in the claim cycle re-sets the latch after the claim clears it.
    edge_pend_d = ((edge_pend_q & ~claim_hit) | rise) & mode_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      edge_pend_q <= '0;
      in_svc_q    <= '0;
      enable_q    <= '0;
      mode_q      <= '0;
      thr_q       <= '0;
      prio_q      <= '0;
      rdata_q     <= '0;
      exti_q      <= 1'b0;
      state_q     <= BUS_IDLE;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      edge_pend_q <= edge_pend_d;
      in_svc_q    <= in_svc_d;
      enable_q    <= enable_d;
      mode_q      <= mode_d;
      thr_q       <= thr_d;
      prio_q      <= prio_d;
      rdata_q     <= rdata_d;
      exti_q      <= exti_d;
      state_q     <= state_d;
    end
  end

  assign bus.bus_ready = (state_q == BUS_RESP);
  assign bus.bus_rdata = rdata_q;
  assign exti          = exti_q;

endmodule

// File: tb/tb_ext_int_arb.sv
module tb_ext_int_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:1] irq_src;
  logic       exti;

  ext_int_arb_if bif();

  ext_int_arb #(.SOURCES(8), .PRIO_W(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .irq_src (irq_src),
    .bus     (bif),
    .exti    (exti)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Monitor: every bus_ready pops one expectation; reads are compared.
  always @(negedge clk) begin
    if (rst_n && bif.bus_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: bus_ready=1 with no access outstanding");
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.chk) begin
          checks++;
          if (bif.bus_rdata !== mon_e.exp) begin
            errors++;
            $display("FAIL %s: rdata=0x%08h expected 0x%08h", mon_e.name, bif.bus_rdata, mon_e.exp);
          end
        end
      end
    end
  end

  task automatic chk_bit(input string nm, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    exp_t e;
    e.chk = 1'b0; e.exp = '0; e.name = "write";
    sb_q.push_back(e);
    bif.bus_sel = 1'b1; bif.bus_we = 1'b1; bif.bus_addr = a; bif.bus_wdata = d;
    @(posedge clk); #1;
    bif.bus_sel = 1'b0; bif.bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [31:0] exp, input string nm);
    exp_t e;
    e.chk = 1'b1; e.exp = exp; e.name = nm;
    sb_q.push_back(e);
    bif.bus_sel = 1'b1; bif.bus_we = 1'b0; bif.bus_addr = a; bif.bus_wdata = '0;
    @(posedge clk); #1;
    bif.bus_sel = 1'b0;
  endtask

  task automatic pulse(input int id);
    irq_src[id] = 1'b1;
    @(posedge clk); #1;
    irq_src[id] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; irq_src = '0;
    bif.bus_sel = 1'b0; bif.bus_we = 1'b0; bif.bus_addr = '0; bif.bus_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_cyc(1);

    // 1. Reset: raise exti via a level source, then reset in the middle of an access.
    bus_write(8'h04, 32'h02);
    bus_write(8'h24, 32'h1);
    irq_src[1] = 1'b1;
    wait_cyc(4);
    chk_bit("exti_before_reset", exti, 1'b1);
    bif.bus_sel = 1'b1; bif.bus_we = 1'b0; bif.bus_addr = 8'h00;
    @(posedge clk); #1;
    bif.bus_sel = 1'b0;
    chk_bit("ready_before_reset", bif.bus_ready, 1'b1);
    rst_n = 1'b0; irq_src = '0;
    #1;
    chk_bit("reset_ready", bif.bus_ready, 1'b0);
    chk_bit("reset_exti", exti, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_cyc(1);
    bus_read(8'h00, 32'h0, "rst_pending");
    bus_read(8'h04, 32'h0, "rst_enable");
    bus_read(8'h08, 32'h0, "rst_mode");
    bus_read(8'h0C, 32'h0, "rst_thresh");
    bus_read(8'h10, 32'h0, "rst_claim");
    for (int i = 1; i <= 8; i++) bus_read(8'(32'h20 + 4 * i), 32'h0, $sformatf("rst_prio%0d", i));
    chk_bit("rst_exti_after", exti, 1'b0);

    // 2. Edge source 3, prio 2, threshold 0.
    bus_write(8'h08, 32'h08);
    bus_write(8'h2C, 32'h2);
    bus_write(8'h0C, 32'h0);
    bus_write(8'h04, 32'h08);
    bus_read(8'h04, 32'h08, "rb_enable");
    bus_read(8'h08, 32'h08, "rb_mode");
    bus_read(8'h2C, 32'h2, "rb_prio3");
    pulse(3);
    wait_cyc(1);
    chk_bit("edge_exti_early", exti, 1'b0);
    wait_cyc(1);
    chk_bit("edge_exti_3cyc", exti, 1'b1);
    bus_read(8'h00, 32'h08, "edge_pending");
    bus_read(8'h10, 32'h3, "edge_claim3");
    wait_cyc(1);
    chk_bit("edge_exti_after_claim", exti, 1'b0);
    bus_read(8'h10, 32'h0, "edge_claim_again");
    bus_write(8'h10, 32'h3);

    // 3. Priority and tie: src2/src5 prio 5, src7 prio 6.
    bus_write(8'h08, 32'hAC);
    bus_write(8'h28, 32'h5);
    bus_write(8'h34, 32'h5);
    bus_write(8'h3C, 32'h6);
    bus_write(8'h04, 32'hAC);
    irq_src[2] = 1'b1; irq_src[5] = 1'b1; irq_src[7] = 1'b1;
    @(posedge clk); #1;
    irq_src = '0;
    wait_cyc(2);
    chk_bit("prio_exti", exti, 1'b1);
    bus_read(8'h10, 32'h7, "prio_claim7");
    bus_write(8'h0C, 32'h5);
    wait_cyc(1);
    chk_bit("thresh5_exti", exti, 1'b0);
    bus_read(8'h0C, 32'h5, "rb_thresh5");
    bus_read(8'h10, 32'h0, "thresh5_claim");
    bus_write(8'h0C, 32'h0);
    wait_cyc(1);
    chk_bit("thresh0_exti", exti, 1'b1);
    bus_read(8'h10, 32'h2, "tie_claim2");
    bus_read(8'h10, 32'h5, "tie_claim5");
    bus_write(8'h10, 32'h7);
    bus_write(8'h10, 32'h2);
    bus_write(8'h10, 32'h5);
    wait_cyc(1);
    chk_bit("prio_exti_idle", exti, 1'b0);

    // 4. Level source 1 held high.
    bus_write(8'h24, 32'h1);
    bus_write(8'h04, 32'h02);
    irq_src[1] = 1'b1;
    wait_cyc(3);
    bus_read(8'h00, 32'h02, "lvl_pending");
    bus_read(8'h10, 32'h1, "lvl_claim1");
    bus_read(8'h00, 32'h00, "lvl_pending_insvc");
    chk_bit("lvl_exti_insvc", exti, 1'b0);
    bus_write(8'h10, 32'h1);
    bus_read(8'h00, 32'h02, "lvl_pending_reassert");
    chk_bit("lvl_exti_reassert", exti, 1'b1);
    irq_src[1] = 1'b0;
    wait_cyc(4);
    chk_bit("lvl_exti_released", exti, 1'b0);

    // 5. Collision on edge source 4.
    bus_write(8'h08, 32'h10);
    bus_write(8'h30, 32'h3);
    bus_write(8'h04, 32'h10);
    pulse(4);
    wait_cyc(2);
    chk_bit("col_exti", exti, 1'b1);
    irq_src[4] = 1'b1;
    wait_cyc(1);
    bus_read(8'h10, 32'h4, "col_claim4");
    irq_src[4] = 1'b0;
    bus_read(8'h00, 32'h10, "col_pending_kept");
    bus_read(8'h10, 32'h0, "col_reclaim");
    chk_bit("col_exti_gated", exti, 1'b0);
    bus_write(8'h10, 32'h4);
    wait_cyc(1);
    chk_bit("col_exti_after_complete", exti, 1'b1);
    bus_read(8'h10, 32'h4, "col_claim4_again");

    // 6. Bad completes and ignored writes (source 4 in service and pending).
    pulse(4);
    wait_cyc(3);
    chk_bit("bad_exti_gated", exti, 1'b0);
    bus_write(8'h10, 32'h0);
    bus_write(8'h10, 32'h9);
    bus_write(8'h10, 32'h3);
    bus_write(8'h00, 32'hFF);
    bus_write(8'h14, 32'hFF);
    bus_read(8'h00, 32'h10, "bad_pending");
    bus_read(8'h10, 32'h0, "bad_claim");
    bus_read(8'h14, 32'h0, "unmapped_read");
    bus_read(8'h44, 32'h0, "prio9_unmapped");
    bus_read(8'h04, 32'h10, "bad_enable_kept");
    chk_bit("bad_exti_still_gated", exti, 1'b0);
    bus_write(8'h10, 32'h4);
    wait_cyc(1);
    chk_bit("good_complete_exti", exti, 1'b1);
    bus_read(8'h10, 32'h4, "good_claim4");
    bus_write(8'h10, 32'h4);

    wait_cyc(3);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL missing_ready: %0d accesses outstanding, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
